// File: rtl/ts_tracklet_cnt_reader_pkg.sv
// Shared constants for the tracklet count reader: default count width,
// layout of the packed count FIFO word, module-pair encodings and the
// reader FSM state type.
package ts_tracklet_cnt_reader_pkg;

  localparam int unsigned TRACKLET_CNT_BITS        = 6;
  localparam int unsigned STRUCT_TRACKLET_CNT_BITS = 3 * TRACKLET_CNT_BITS;

  // Field bounds within the packed count word (a in the top slice).
  localparam int unsigned TRACKLET_CNT_A_MSB = 3 * TRACKLET_CNT_BITS - 1;
  localparam int unsigned TRACKLET_CNT_A_LSB = 2 * TRACKLET_CNT_BITS;
  localparam int unsigned TRACKLET_CNT_B_MSB = 2 * TRACKLET_CNT_BITS - 1;
  localparam int unsigned TRACKLET_CNT_B_LSB = TRACKLET_CNT_BITS;
  localparam int unsigned TRACKLET_CNT_C_MSB = TRACKLET_CNT_BITS - 1;
  localparam int unsigned TRACKLET_CNT_C_LSB = 0;

  // Module-pair encodings carried on trk_pair.
  localparam logic [1:0] PAIR_A = 2'd0;
  localparam logic [1:0] PAIR_B = 2'd1;
  localparam logic [1:0] PAIR_C = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SCAN,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/ts_tracklet_cnt_reader.sv
// Tracklet count reader: pops one packed count word (a/b/c) from a
// standard-read FIFO, then walks the three module pairs emitting one
// (pair, index) request per tracklet under a valid/ready handshake, and
// pulses event_done once every request of the word has been accepted.
module ts_tracklet_cnt_reader
  import ts_tracklet_cnt_reader_pkg::*;
#(
  parameter int unsigned CNT_BITS = TRACKLET_CNT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3*CNT_BITS-1:0] struct_tracklet_cnt,
  input  logic                  tracklet_cnt_fifo_empty,
  output logic                  rd_en,
  input  logic                  trk_ready,
  output logic                  trk_valid,
  output logic [1:0]            trk_pair,
  output logic [CNT_BITS-1:0]   trk_index,
  output logic                  event_done,
  output logic                  busy
);

  // Package bounds describe the default-width word; scale the field slot
  // positions so a non-default CNT_BITS keeps the same a/b/c ordering.
  localparam int unsigned A_LSB = (TRACKLET_CNT_A_LSB / TRACKLET_CNT_BITS) * CNT_BITS;
  localparam int unsigned B_LSB = (TRACKLET_CNT_B_LSB / TRACKLET_CNT_BITS) * CNT_BITS;
  localparam int unsigned C_LSB = (TRACKLET_CNT_C_LSB / TRACKLET_CNT_BITS) * CNT_BITS;

  rd_state_t           state;
  logic [CNT_BITS-1:0] cnt_a;
  logic [CNT_BITS-1:0] cnt_b;
  logic [CNT_BITS-1:0] cnt_c;
  logic [CNT_BITS-1:0] fld_a;
  logic [CNT_BITS-1:0] fld_b;
  logic [CNT_BITS-1:0] fld_c;
  logic [CNT_BITS-1:0] cur_cnt;
  logic [CNT_BITS-1:0] nxt_cnt;
  logic                last_pair;
  logic                last_index;
  logic                accept;

  assign fld_a = struct_tracklet_cnt[A_LSB +: CNT_BITS];
  assign fld_b = struct_tracklet_cnt[B_LSB +: CNT_BITS];
  assign fld_c = struct_tracklet_cnt[C_LSB +: CNT_BITS];

  // Count of the pair being scanned and of the pair that follows it.
  always_comb begin
    cur_cnt = '0;
    nxt_cnt = '0;
    case (trk_pair)
      PAIR_A: begin
        cur_cnt = cnt_a;
        nxt_cnt = cnt_b;
      end
      PAIR_B: begin
        cur_cnt = cnt_b;
        nxt_cnt = cnt_c;
      end
      PAIR_C: begin
        cur_cnt = cnt_c;
      end
      default: begin
        cur_cnt = '0;
      end
    endcase
  end

  assign last_pair  = (trk_pair == PAIR_C);
  assign last_index = (trk_index == cur_cnt - CNT_BITS'(1));
  assign accept     = trk_valid & trk_ready;

  // Reader FSM with all outputs registered. rd_en is raised in IDLE one
  // cycle after a non-empty FIFO is seen and the move to FETCH happens on
  // the edge that ends the pop cycle, so the pop strobe only ever appears
  // while the FSM is in IDLE. In SCAN trk_valid always equals (count != 0)
  // for the current pair, so a zero-count pair costs exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rd_en      <= 1'b0;
      trk_valid  <= 1'b0;
      trk_pair   <= PAIR_A;
      trk_index  <= '0;
      event_done <= 1'b0;
      busy       <= 1'b0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      cnt_c      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_en) begin
            rd_en <= 1'b0;
            busy  <= 1'b1;
            state <= ST_FETCH;
          end else if (!tracklet_cnt_fifo_empty) begin
            rd_en <= 1'b1;
          end
        end

        ST_FETCH: begin
          cnt_a     <= fld_a;
          cnt_b     <= fld_b;
          cnt_c     <= fld_c;
          trk_pair  <= PAIR_A;
          trk_index <= '0;
          trk_valid <= (fld_a != '0);
          state     <= ST_SCAN;
        end

        ST_SCAN: begin
          if ((cur_cnt == '0) || (accept && last_index)) begin
            trk_index <= '0;
            if (last_pair) begin
              trk_valid  <= 1'b0;
              event_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              trk_pair  <= trk_pair + 2'd1;
              trk_valid <= (nxt_cnt != '0);
            end
          end else if (accept) begin
            trk_index <= trk_index + CNT_BITS'(1);
          end
        end

        ST_DONE: begin
          event_done <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_tracklet_cnt_reader.sv
// Directed bench for ts_tracklet_cnt_reader with a small standard-read FIFO
// model feeding the DUT and a per-cycle trace of its outputs.
module tb_ts_tracklet_cnt_reader;
  import ts_tracklet_cnt_reader_pkg::*;

  localparam int unsigned CB = TRACKLET_CNT_BITS;

  logic            clk = 1'b0;
  logic            reset;
  logic [3*CB-1:0] dout;
  logic            empty;
  logic            rd_en;
  logic            trk_ready;
  logic            trk_valid;
  logic [1:0]      trk_pair;
  logic [CB-1:0]   trk_index;
  logic            event_done;
  logic            busy;

  int total = 0;
  int bad   = 0;

  logic [3*CB-1:0] fifo_q[$];
  logic            ready_q[$];
  logic            pop_pending;

  int cyc;
  int rd_cyc[$];
  int done_cyc[$];
  int valid_cyc[$];
  int acc[$];
  int rd_in_busy;
  int hold_bad;
  int stall_cnt;
  logic       prev_stall;
  logic [1:0] prev_pair;
  logic [CB-1:0] prev_idx;

  ts_tracklet_cnt_reader #(.CNT_BITS(CB)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .struct_tracklet_cnt     (dout),
    .tracklet_cnt_fifo_empty (empty),
    .rd_en                   (rd_en),
    .trk_ready               (trk_ready),
    .trk_valid               (trk_valid),
    .trk_pair                (trk_pair),
    .trk_index               (trk_index),
    .event_done              (event_done),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_word(input int a, input int b, input int c);
    logic [3*CB-1:0] w;
    w = '0;
    w[TRACKLET_CNT_A_MSB:TRACKLET_CNT_A_LSB] = CB'(a);
    w[TRACKLET_CNT_B_MSB:TRACKLET_CNT_B_LSB] = CB'(b);
    w[TRACKLET_CNT_C_MSB:TRACKLET_CNT_C_LSB] = CB'(c);
    fifo_q.push_back(w);
  endtask

  task automatic clear_trace();
    cyc = 0;
    rd_cyc.delete();
    done_cyc.delete();
    valid_cyc.delete();
    acc.delete();
    ready_q.delete();
    rd_in_busy = 0;
    hold_bad   = 0;
    stall_cnt  = 0;
    prev_stall = 1'b0;
    prev_pair  = '0;
    prev_idx   = '0;
  endtask

  // One clock: FIFO/ready update just after the rising edge, trace sample
  // on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pending) begin
      if (fifo_q.size() > 0) dout = fifo_q.pop_front();
      pop_pending = 1'b0;
    end
    empty     = (fifo_q.size() == 0);
    trk_ready = (ready_q.size() > 0) ? ready_q.pop_front() : 1'b1;
    @(negedge clk);
    cyc++;
    if (rd_en) begin
      rd_cyc.push_back(cyc);
      pop_pending = 1'b1;
      if (busy) rd_in_busy++;
    end
    if (prev_stall && !(trk_valid && trk_pair == prev_pair && trk_index == prev_idx))
      hold_bad++;
    if (trk_valid) valid_cyc.push_back(cyc);
    if (trk_valid && !trk_ready) stall_cnt++;
    if (trk_valid && trk_ready) acc.push_back(int'(trk_pair) * 64 + int'(trk_index));
    if (event_done) done_cyc.push_back(cyc);
    prev_stall = trk_valid && !trk_ready;
    prev_pair  = trk_pair;
    prev_idx   = trk_index;
  endtask

  initial begin
    int got_idx1;
    reset       = 1'b0;
    empty       = 1'b1;
    trk_ready   = 1'b1;
    dout        = '0;
    pop_pending = 1'b0;
    clear_trace();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_rd_en", int'(rd_en), 0);
    check_val("rst_valid", int'(trk_valid), 0);
    check_val("rst_done", int'(event_done), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_pair", int'(trk_pair), 0);
    check_val("rst_index", int'(trk_index), 0);

    // a=2 b=0 c=1, word waiting at reset release
    push_word(2, 0, 1);
    empty = 1'b0;
    clear_trace();
    reset = 1'b1;
    #1;
    check_val("rel_rd_en_low", int'(rd_en), 0);
    repeat (12) tick();
    check_val("w1_rd_cnt", rd_cyc.size(), 1);
    check_val("w1_rd_cyc", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, 1);
    check_val("w1_first_valid", (valid_cyc.size() > 0) ? valid_cyc[0] : -1, 3);
    check_val("w1_acc_cnt", acc.size(), 3);
    check_val("w1_req0", (acc.size() > 0) ? acc[0] : -1, 0);
    check_val("w1_req1", (acc.size() > 1) ? acc[1] : -1, 1);
    check_val("w1_req2", (acc.size() > 2) ? acc[2] : -1, 128);
    check_val("w1_skip_b", (valid_cyc.size() > 2) ? valid_cyc[2] : -1, 6);
    check_val("w1_done_cnt", done_cyc.size(), 1);
    check_val("w1_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, 7);
    check_val("w1_idle_busy", int'(busy), 0);

    // a=3 with 4 stall cycles on the first request
    clear_trace();
    push_word(3, 0, 0);
    ready_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (18) tick();
    check_val("w2_rd_cnt", rd_cyc.size(), 1);
    check_val("w2_first_valid", (valid_cyc.size() > 0 && rd_cyc.size() > 0) ? valid_cyc[0] - rd_cyc[0] : -1, 2);
    check_val("w2_stall", stall_cnt, 4);
    check_val("w2_hold", hold_bad, 0);
    check_val("w2_acc_cnt", acc.size(), 3);
    check_val("w2_req0", (acc.size() > 0) ? acc[0] : -1, 0);
    check_val("w2_req1", (acc.size() > 1) ? acc[1] : -1, 1);
    check_val("w2_req2", (acc.size() > 2) ? acc[2] : -1, 2);
    check_val("w2_done", (done_cyc.size() > 0 && rd_cyc.size() > 0) ? done_cyc[0] - rd_cyc[0] : -1, 11);

    // All-zero word
    clear_trace();
    push_word(0, 0, 0);
    repeat (12) tick();
    check_val("w3_valid_cnt", valid_cyc.size(), 0);
    check_val("w3_done_cnt", done_cyc.size(), 1);
    check_val("w3_done_lat", (done_cyc.size() > 0 && rd_cyc.size() > 0) ? done_cyc[0] - rd_cyc[0] : -1, 5);

    // Two queued words, a=1 each
    clear_trace();
    push_word(1, 0, 0);
    push_word(1, 0, 0);
    repeat (25) tick();
    check_val("w4_rd_cnt", rd_cyc.size(), 2);
    check_val("w4_rd_in_busy", rd_in_busy, 0);
    check_val("w4_done_cnt", done_cyc.size(), 2);
    check_val("w4_acc_cnt", acc.size(), 2);
    check_val("w4_second_pop_after_done",
              (rd_cyc.size() > 1 && done_cyc.size() > 0) ? int'(rd_cyc[1] > done_cyc[0]) : 0, 1);

    // c=63, maximum count
    clear_trace();
    push_word(0, 0, 63);
    repeat (80) tick();
    check_val("w5_acc_cnt", acc.size(), 63);
    for (int i = 0; i < 63; i++)
      check_val($sformatf("w5_req%0d", i), (acc.size() > i) ? acc[i] : -1, 128 + i);
    check_val("w5_done_cnt", done_cyc.size(), 1);

    // a=5, reset during pair-a index 1
    clear_trace();
    push_word(5, 0, 0);
    got_idx1 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (trk_valid && trk_pair == PAIR_A && trk_index == CB'(1)) begin
        got_idx1 = 1;
        break;
      end
    end
    check_val("w6_reach_idx1", got_idx1, 1);
    reset = 1'b0;
    #1;
    check_val("w6_rst_valid", int'(trk_valid), 0);
    check_val("w6_rst_index", int'(trk_index), 0);
    check_val("w6_rst_busy", int'(busy), 0);
    @(negedge clk);
    check_val("w6_rst_pair", int'(trk_pair), 0);
    check_val("w6_rst_done", int'(event_done), 0);
    check_val("w6_rst_rd_en", int'(rd_en), 0);
    fifo_q.delete();
    pop_pending = 1'b0;
    empty = 1'b1;
    clear_trace();
    reset = 1'b1;
    repeat (10) tick();
    check_val("w6_post_rd_cnt", rd_cyc.size(), 0);
    check_val("w6_post_done_cnt", done_cyc.size(), 0);
    check_val("w6_post_valid_cnt", valid_cyc.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
